rca_pipe: RTL
=============

// Module: rca_pipe
// PURPOSE
//  Parametrised, pipelined ripple-carry adder/subtractor; successor to the 4-bit full-adder chain.
//  Splits a WIDTH-bit add into STAGES chunks, one chunk of full adders per pipeline stage.
//  The carry is registered between stages, so each stage only ripples through one chunk.
//  Sits on datapaths that need wide add/sub at high clock rate; valid/ready on both sides.
// PARAMETERS
//  WIDTH   16  operand/sum width in bits; WIDTH % STAGES == 0 (elaboration error otherwise)
//  STAGES  4   pipeline stages; CHUNK = WIDTH/STAGES bits added per stage; STAGES >= 1
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      a/b/c_in/sub valid this cycle
//  in_ready   out  1      block accepts input this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  c_in       in   1      carry in (add mode only)
//  sub        in   1      0: s = a+b+c_in; 1: s = a-b (c_in ignored)
//  out_valid  out  1      s/c_out/ovf valid
//  out_ready  in   1      downstream accepts result
//  s          out  WIDTH  sum/difference
//  c_out      out  1      carry out of MSB (sub: 1 = no borrow, 0 = borrow)
//  ovf        out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all stage valids, out_valid, s, c_out, ovf and all pipeline data/carry regs -> 0.
//    Reset has priority over every other event; in-flight operations are discarded, not completed.
//  - Sub mode: b is bitwise inverted and stage-0 carry-in forced to 1 at the input; sub travels with the data.
//  - Stage k (0..STAGES-1) adds chunk k [k*CHUNK +: CHUNK] of a and b' with the carry registered by stage k-1
//    (stage 0 uses the effective carry-in), and registers the chunk sum plus its carry out.
//  - Upper operand chunks are skew-delayed and completed lower sum chunks are delay-aligned, so all chunks
//    of one operation emerge together.
//  - ovf = (a[MSB] == b'[MSB]) && (s[MSB] != a[MSB]), using inverted b' in sub mode; computed in last stage.
//  - Latency: accept at posedge N -> out_valid=1 with result after posedge N+STAGES-1 (visible cycle N+STAGES-1 .. i.e.
//    STAGES register stages; STAGES=1 gives one-cycle registered adder).
//  - Handshake: advance = ~out_valid | out_ready; in_ready = advance (combinational, also depends on out_ready).
//    Input accepted when in_valid & in_ready. Whole pipeline shifts on advance; holds completely when ~advance.
//    Bubbles (invalid slots) are carried, not collapsed.
//  - While out_valid & ~out_ready: s, c_out, ovf, out_valid held stable; no input accepted; nothing lost.
//  - Full throughput: with out_ready=1, one result per cycle, strictly in input order.
//  - in_valid=0 on an advance cycle inserts a bubble; out_valid=0 for that slot STAGES cycles later.
//  - Input values are ignored (don't care) when in_valid=0; outputs don't care when out_valid=0 but never X after reset.
//  - Wrap-around: sums are modulo 2^WIDTH; carry out of MSB appears only on c_out.
// TESTING  (WIDTH=16, STAGES=4 unless noted; out_ready=1 unless noted)
//  1. add a=0x1234 b=0x1111 c_in=0 -> exactly 4 cycles later out_valid=1, s=0x2345, c_out=0, ovf=0.
//  2. add a=0xFFFF b=0x0001 c_in=0 -> s=0x0000 c_out=1 ovf=0; a=0x7FFF b=0x0000 c_in=1 -> s=0x8000 c_out=0 ovf=1.
//  3. sub a=0x0005 b=0x0007 -> s=0xFFFE c_out=0 ovf=0; sub a=0x8000 b=0x0001 -> s=0x7FFF c_out=1 ovf=1.
//  4. 8 back-to-back inputs with mixed add/sub and one bubble -> 8 results in order, one bubble slot, matching model.
//  5. out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0, s/c_out/ovf stable; release -> no loss/duplication.
//  6. rst=1 with 3 ops in flight -> next cycle out_valid=0, s=0, in_ready=1; no stale result ever appears.
//     Repeat tests 1-5 with STAGES=1 and with WIDTH=32, STAGES=8 against a randomised reference model.

Source files
------------

// File: rtl/rca_pipe_if.sv
// Operand/result bundle for rca_pipe: valid/ready on the input and output sides.
interface rca_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  // Master supplies operands and consumes results; slave is the adder.
  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, s, c_out, ovf
  );
  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, s, c_out, ovf
  );
endinterface

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor. Each stage ripples one CHUNK of
// full adders and registers its carry; all stages share a single advance.
module rca_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic       clk,
  input logic       rst,
  rca_pipe_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_chk
    $error("rca_pipe: WIDTH must be a non-zero multiple of STAGES");
  end

  // Stage k holds the a/sum word plus the b' chunks that are still to be added.
  function automatic int stg_w(input int k);
    return WIDTH + (STAGES - 1 - k) * CHUNK;
  endfunction

  function automatic int stg_off(input int k);
    int off = 0;
    for (int j = 0; j < k; j++) off += stg_w(j);
    return off;
  endfunction

  // Every stage register lives in one triangular vector; only live bits are stored.
  localparam int TOT_W = stg_off(STAGES);

  logic [TOT_W-1:0]   pipe_d, pipe_q;
  logic [STAGES-1:0]  cy_d, cy_q;
  logic [STAGES-1:0]  vld_d, vld_q;
  logic               ovf_d, ovf_q;
  logic [2*WIDTH-1:0] in_word;
  logic               cin_eff;
  logic               advance;

  // Subtraction folds into the operands: b inverted, carry-in forced high.
  always_comb begin
    in_word = {(bus.sub ? ~bus.b : bus.b), bus.a};
    cin_eff = bus.sub | bus.c_in;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int RW  = stg_w(k);
    localparam int OFF = stg_off(k);
    localparam int LO  = k * CHUNK;

    logic [RW+CHUNK-1:0] x_in;
    logic                c_prev;
    logic [WIDTH-1:0]    word;
    logic [CHUNK-1:0]    sum;
    logic                c;

    if (k == 0) begin : g_src
      assign x_in   = in_word;
      assign c_prev = cin_eff;
    end else begin : g_src
      assign x_in   = pipe_q[stg_off(k-1) +: RW + CHUNK];
      assign c_prev = cy_q[k-1];
    end

    // One chunk of full adders rippling from the previous stage's carry;
    // the sum replaces chunk k of the a word, lower chunks pass through.
    always_comb begin
      c   = c_prev;
      sum = '0;
      for (int i = 0; i < CHUNK; i++) begin
        sum[i] = x_in[LO+i] ^ x_in[WIDTH+i] ^ c;
        c      = (x_in[LO+i] & x_in[WIDTH+i]) | (c & (x_in[LO+i] ^ x_in[WIDTH+i]));
      end
      word             = x_in[WIDTH-1:0];
      word[LO+:CHUNK]  = sum;
    end

    if (k < STAGES - 1) begin : g_nxt
      // b' chunk k is consumed; the remaining b' chunks skew down the pipe.
      assign pipe_d[OFF +: RW] = {x_in[RW+CHUNK-1:WIDTH+CHUNK], word};
    end else begin : g_nxt
      assign pipe_d[OFF +: RW] = word;
      // Operand MSBs are still visible here because the top chunk is summed now.
      assign ovf_d = (x_in[WIDTH-1] == x_in[WIDTH+CHUNK-1]) &&
                     (sum[CHUNK-1] != x_in[WIDTH-1]);
    end
    assign cy_d[k] = c;
  end

  // Advance only when the output slot is empty or being drained; bubbles shift like data.
  always_comb begin
    advance  = ~vld_q[STAGES-1] | bus.out_ready;
    vld_d    = vld_q << 1;
    vld_d[0] = bus.in_valid;
  end

  // Whole pipeline moves together; a stalled output freezes every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
      cy_q   <= '0;
      vld_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (advance) begin
      pipe_q <= pipe_d;
      cy_q   <= cy_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.s         = pipe_q[stg_off(STAGES-1) +: WIDTH];
  assign bus.c_out     = cy_q[STAGES-1];
  assign bus.ovf       = ovf_q;
endmodule
